lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_LIMIT, 256, byte-address bound; addresses >= ADDR_LIMIT are errors (64-word data memory).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  load/store request present.
REQ-005 req_ready  out  1  lsu_ctrl accepts the request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  consumer takes the response.
REQ-013 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned, illegal-size or out-of-range request.
REQ-015 mem_we  out  1  write enable to data memory.
REQ-016 mem_adr  out  32  byte address to data memory.
REQ-017 mem_wd  out  32  write data to data memory.
REQ-018 mem_mode  out  2  00 word, 01 half, 10 byte; same encoding as req_size.
REQ-019 mem_rd  in  32  combinational read word from data memory, word-aligned.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; req_ready = (state==IDLE).
REQ-021 Handshake fires on req_valid&&req_ready; addr, size, we, unsigned and wdata are registered on the handshake edge.
REQ-022 Error on a handshake if size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr>=ADDR_LIMIT.
REQ-023 IDLE->ACCESS on a valid handshake; IDLE->RESP with rsp_err=1 on an erroring handshake; IDLE holds otherwise.
REQ-024 ACCESS lasts exactly one cycle, then goes to RESP.
REQ-025 In ACCESS: mem_adr=registered addr; mem_mode=registered size; mem_wd=registered wdata unshifted; mem_we=store && reset_n.
REQ-026 mem_we=0 in IDLE and RESP; a request produces at most one mem_we cycle; errors produce none.
REQ-027 Load data is captured from mem_rd at the end of ACCESS.
REQ-028 Byte load uses lane addr[1:0]; half load uses [31:16] if addr[1] else [15:0]; word load uses all 32 bits; then extend per unsigned.
REQ-029 RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
REQ-030 RESP->IDLE on rsp_ready; no new request is accepted in the same cycle.
REQ-031 Latency: rsp_valid rises 2 cycles after a normal handshake and 1 cycle after an erroring handshake.
REQ-032 mem_adr, mem_wd and mem_mode are 0 outside ACCESS.

Reset
REQ-033 While reset_n=0 at posedge: state=IDLE and all captured registers are 0.
REQ-034 Out of reset: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_adr/mem_wd/mem_mode=0.
REQ-035 Reset in ACCESS or RESP aborts the request with no response; a store in ACCESS is not written (mem_we is gated by reset_n).

Structure
REQ-036 Package lsu_pkg holds: size enum (SZ_WORD, SZ_HALF, SZ_BYTE), state enum, default ADDR_LIMIT.
REQ-037 Sub-module load_ext: combinational lane select plus sign/zero extension; it is instantiated once.

Verification
REQ-038 Store byte 0xA5 at 0x13: one mem_we cycle with mode 10, adr 0x13. Then lb at 0x13 returns 0xFFFFFFA5 and lbu returns 0x000000A5, err=0.
REQ-039 Memory word at 0x10 = 0x80017FFF: lh 0x12 returns 0xFFFF8001; lhu 0x12 returns 0x00008001; lh 0x10 returns 0x00007FFF.
REQ-040 lw at 0x06: rsp_valid 1 cycle after the handshake, err=1, rdata=0, mem_we never high. The same holds for size=11 and for addr 0x100.
REQ-041 rsp_ready held low 5 cycles in RESP: rsp_valid, rsp_rdata and rsp_err stay stable; req_ready=0; mem_we=0.
REQ-042 reset_n driven low during ACCESS of sw 0xDEADBEEF to 0x20: mem_we=0 that cycle, the word at 0x20 is unchanged, next state IDLE with all outputs at reset values.
REQ-043 Back-to-back sw/lw at 0x04 with rsp_ready tied high: the load returns the stored word, and each request takes 3 cycles from handshake to next req_ready.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types: access sizes, controller states and the default
// data-memory address bound.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic [31:0] LSU_ADDR_LIMIT = 32'd256;

endpackage

// File: rtl/load_ext.sv
// Load lane select from a word-aligned read word, then sign or zero
// extension to 32 bits.
module load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rd[7:0];
        case (i_off)
            2'b01:   w_byte = i_rd[15:8];
            2'b10:   w_byte = i_rd[23:16];
            2'b11:   w_byte = i_rd[31:24];
            default: w_byte = i_rd[7:0];
        endcase
        w_half = i_off[1] ? i_rd[31:16] : i_rd[15:0];
    end

    always_comb begin
        o_data = i_rd;
        case (i_size)
            SZ_HALF: o_data = {{16{w_half[15] & ~i_uns}}, w_half};
            SZ_BYTE: o_data = {{24{w_byte[7] & ~i_uns}}, w_byte};
            default: o_data = i_rd;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, IDLE -> ACCESS -> RESP,
// with errored requests skipping the memory access entirely.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = LSU_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic [1:0]  mem_mode,
    input  logic [31:0] mem_rd
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic        w_hs;
    logic        w_err;
    logic [31:0] w_ext;

    assign w_hs = req_valid && (r_state == IDLE);

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_WORD: w_err = (req_addr[1:0] != 2'b00);
            SZ_HALF: w_err = req_addr[0];
            SZ_BYTE: w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
        if (req_addr >= ADDR_LIMIT) begin
            w_err = 1'b1;
        end
    end

    load_ext u_load_ext (
        .i_rd   (mem_rd),
        .i_off  (r_addr[1:0]),
        .i_size (r_size),
        .i_uns  (r_uns),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= w_err;
                r_rdata <= '0;
            end
            // stores leave r_rdata at the zero set on the handshake
            if (r_state == ACCESS && !r_we) begin
                r_rdata <= w_ext;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wd    = '0;
        mem_mode  = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_we   = r_we && reset_n;
                mem_adr  = r_addr;
                mem_wd   = r_wdata;
                mem_mode = r_size;
                w_next   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = r_rdata;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-addressed reference memory, directed corner
// cases and randomized load/store traffic.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [1:0]  mem_mode;
    logic [31:0] mem_rd;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wd       (mem_wd),
        .mem_mode     (mem_mode),
        .mem_rd       (mem_rd)
    );

    // data memory attached to the DUT
    assign mem_rd = mem[mem_adr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_mode)
                2'b00: mem[mem_adr[7:2]] <= mem_wd;
                2'b01: mem[mem_adr[7:2]][{mem_adr[1], 4'b0000} +: 16] <= mem_wd[15:0];
                2'b10: mem[mem_adr[7:2]][{mem_adr[1:0], 3'b000} +: 8] <= mem_wd[7:0];
                default: ;
            endcase
        end
    end

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (a >= 32'd256) return 1'b1;
        if (sz == 2'b00) return (a % 4) != 0;
        if (sz == 2'b01) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = a[7:0];
        h = {ref_b[b + 8'd1], ref_b[b]};
        case (sz)
            2'b00: v = {ref_b[b + 8'd3], ref_b[b + 8'd2], h};
            2'b01: v = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: v = uns ? {24'h0, ref_b[b]} : {{24{ref_b[b][7]}}, ref_b[b]};
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        logic [7:0] b;
        b = a[7:0];
        ref_b[b] = d[7:0];
        if (sz != 2'b10) ref_b[b + 8'd1] = d[15:8];
        if (sz == 2'b00) begin
            ref_b[b + 8'd2] = d[23:16];
            ref_b[b + 8'd3] = d[31:24];
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int wc,
                         output logic [31:0] wa, output logic [31:0] wdo,
                         output logic [1:0] wm);
        int n;
        rd = '0; er = 1'b0; lat = 0; wc = 0; wa = '0; wdo = '0; wm = '0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                wc++; wa = mem_adr; wdo = mem_wd; wm = mem_mode;
            end
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout addr=%h waited=%0d cycles", a, lat);
        end
        rd = rsp_rdata;
        er = rsp_err;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=1000",
                     {req_ready, rsp_valid, rsp_err, mem_we});
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
            bad++;
            $display("FAIL post_reset_ctl got=%b exp=1000",
                     {req_ready, rsp_valid, rsp_err, mem_we});
        end
        total++;
        if ({rsp_rdata, mem_adr, mem_wd, mem_mode} !== 98'h0) begin
            bad++;
            $display("FAIL post_reset_data got=%h/%h/%h/%b exp=0",
                     rsp_rdata, mem_adr, mem_wd, mem_mode);
        end
    endtask

    task automatic test_fill;
        logic [31:0] rd, wa, wd, w;
        logic [1:0]  wm;
        logic        er;
        int lat, wc;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            issue(1'b1, 2'b00, 1'b0, 32'(i * 4), w, rd, er, lat, wc, wa, wd, wm);
            ref_store(2'b00, 32'(i * 4), w);
            total++;
            if (wc !== 1 || wa !== 32'(i * 4) || wd !== w || er !== 1'b0) begin
                bad++;
                $display("FAIL fill_sw i=%0d got we=%0d adr=%h wd=%h err=%b exp 1/%h/%h/0",
                         i, wc, wa, wd, er, 32'(i * 4), w);
            end
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd, wa, wd;
        logic [1:0]  wm;
        logic        er;
        int lat, wc;
        issue(1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_00A5, rd, er, lat, wc, wa, wd, wm);
        ref_store(2'b10, 32'h13, 32'hA5);
        total++;
        if (wc !== 1 || wa !== 32'h13 || wm !== 2'b10 || wd !== 32'hA5) begin
            bad++;
            $display("FAIL sb_mem got we=%0d adr=%h mode=%b wd=%h exp 1/13/10/a5",
                     wc, wa, wm, wd);
        end
        total++;
        if (er !== 1'b0 || rd !== 32'h0 || lat !== 2) begin
            bad++;
            $display("FAIL sb_rsp got err=%b rd=%h lat=%0d exp 0/0/2", er, rd, lat);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'hFFFF_FFA5 || er !== 1'b0 || wc !== 0) begin
            bad++;
            $display("FAIL lb got rd=%h err=%b we=%0d exp ffffffa5/0/0", rd, er, wc);
        end
        issue(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'h0000_00A5 || er !== 1'b0) begin
            bad++;
            $display("FAIL lbu got rd=%h err=%b exp 000000a5/0", rd, er);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd, wa, wd;
        logic [1:0]  wm;
        logic        er;
        int lat, wc;
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h8001_7FFF, rd, er, lat, wc, wa, wd, wm);
        ref_store(2'b00, 32'h10, 32'h8001_7FFF);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin
            bad++;
            $display("FAIL lh_hi got rd=%h err=%b exp ffff8001/0", rd, er);
        end
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'h0000_8001 || er !== 1'b0) begin
            bad++;
            $display("FAIL lhu_hi got rd=%h err=%b exp 00008001/0", rd, er);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'h0000_7FFF || er !== 1'b0) begin
            bad++;
            $display("FAIL lh_lo got rd=%h err=%b exp 00007fff/0", rd, er);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd, wa, wd;
        logic [1:0]  wm;
        logic        er;
        int lat, wc;
        logic        t_we [4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  t_sz [4]   = '{2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] t_ad [4]   = '{32'h06, 32'h08, 32'h100, 32'h104};
        for (int i = 0; i < 4; i++) begin
            issue(t_we[i], t_sz[i], 1'b0, t_ad[i], 32'hFFFF_FFFF,
                  rd, er, lat, wc, wa, wd, wm);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wc !== 0) begin
                bad++;
                $display("FAIL err_case%0d got err=%b rd=%h lat=%0d we=%0d exp 1/0/1/0",
                         i, er, rd, lat, wc);
            end
        end
    endtask

    task automatic test_stall;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01;
        req_unsigned = 1'b0; req_addr = 32'h12;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, rsp_err, req_ready, mem_we} !== 4'b1000 ||
                rsp_rdata !== 32'hFFFF_8001) begin
                bad++;
                $display("FAIL stall%0d got v/e/rdy/we=%b rd=%h exp 1000 ffff8001",
                         i, {rsp_valid, rsp_err, req_ready, mem_we}, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stall_release got rdy/v=%b exp 10", {req_ready, rsp_valid});
        end
    endtask

    task automatic test_reset_access;
        logic [31:0] rd, wa, wd;
        logic [1:0]  wm;
        logic        er;
        int lat, wc;
        issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h1122_3344, rd, er, lat, wc, wa, wd, wm);
        ref_store(2'b00, 32'h20, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || mem_adr !== 32'h20) begin
            bad++;
            $display("FAIL rst_access got we=%b adr=%h exp 0/20", mem_we, mem_adr);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000 ||
            {rsp_rdata, mem_adr, mem_wd, mem_mode} !== 98'h0) begin
            bad++;
            $display("FAIL rst_abort got ctl=%b data=%h/%h/%h/%b exp 1000 zeros",
                     {req_ready, rsp_valid, rsp_err, mem_we},
                     rsp_rdata, mem_adr, mem_wd, mem_mode);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, er, lat, wc, wa, wd, wm);
        total++;
        if (rd !== 32'h1122_3344 || er !== 1'b0) begin
            bad++;
            $display("FAIL rst_nowrite got rd=%h err=%b exp 11223344/0", rd, er);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w, got;
        int n1, n2;
        w = $urandom;
        got = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h04; req_wdata = w;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ref_store(2'b00, 32'h04, w);
        n1 = 1;
        while (!req_ready && n1 < 20) begin
            @(posedge clk);
            #1 n1++;
        end
        req_valid = 1'b1; req_we = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n2 = 1;
        while (!req_ready && n2 < 20) begin
            @(posedge clk);
            #1 n2++;
            if (rsp_valid) got = rsp_rdata;
        end
        rsp_ready = 1'b0;
        total++;
        if (n1 !== 3 || n2 !== 3) begin
            bad++;
            $display("FAIL b2b_cycles got sw=%0d lw=%0d exp 3/3", n1, n2);
        end
        total++;
        if (got !== ref_load(2'b00, 1'b0, 32'h04)) begin
            bad++;
            $display("FAIL b2b_data got=%h exp=%h", got, ref_load(2'b00, 1'b0, 32'h04));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, wa, wd, a, d, exp_rd;
        logic [1:0]  wm, sz;
        logic        er, we, uns, exp_er;
        int lat, wc, exp_lat, exp_wc;
        for (int i = 0; i < 150; i++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 65)) * 4;
            if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'b01) a = a + 32'($urandom_range(0, 1)) * 2;
            else if (sz == 2'b10) a = a + 32'($urandom_range(0, 3));
            d = $urandom;
            exp_er  = ref_err(sz, a);
            exp_lat = exp_er ? 1 : 2;
            exp_wc  = (we && !exp_er) ? 1 : 0;
            exp_rd  = (we || exp_er) ? 32'h0 : ref_load(sz, uns, a);
            issue(we, sz, uns, a, d, rd, er, lat, wc, wa, wd, wm);
            if (we && !exp_er) ref_store(sz, a, d);
            total++;
            if (rd !== exp_rd || er !== exp_er || lat !== exp_lat || wc !== exp_wc) begin
                bad++;
                $display("FAIL rand%0d we=%b sz=%b a=%h got rd=%h e=%b lat=%0d we#=%0d exp %h/%b/%0d/%0d",
                         i, we, sz, a, rd, er, lat, wc, exp_rd, exp_er, exp_lat, exp_wc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_byte();
        test_half();
        test_errors();
        test_stall();
        test_reset_access();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
